nexys_starship_uart_report: RTL and testbench



---
 rtl/nexys_starship_uart_report.sv | 181 ++++++++++++++++++
 tb/tb_nexys_starship_uart_report.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/nexys_starship_uart_report.sv
// ============================================================================
// nexys_starship_uart_report: 8N1 UART sender for the 8-byte game-over report
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module nexys_starship_uart_report #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int BAUD         = 115_200,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
  input  logic       board_clk,
  input  logic       Reset,
  input  logic       start,
  input  logic [1:0] event_code,
  input  logic [3:0] time_min,
  input  logic [3:0] time_sec_10s,
  input  logic [3:0] time_sec_1s,
  output logic       UartTx,
  output logic       busy,
  output logic       done
);

  localparam int             CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA_BITS = 2'd2,
    STOP_BIT  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [2:0]       byte_idx_q, byte_idx_d;
  logic [1:0]       ev_q, ev_d;
  logic [3:0]       min_q, min_d;
  logic [3:0]       s10_q, s10_d;
  logic [3:0]       s1_q, s1_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [7:0]       cur_byte;
  logic [2:0]       next_bit;
  logic             bit_end;

  function automatic logic [7:0] hex_char(input logic [3:0] v);
    return (v < 4'd10) ? (8'h30 + {4'h0, v}) : (8'h37 + {4'h0, v});
  endfunction

  always_comb begin
    cur_byte = 8'h0A;
    case (byte_idx_q)
      3'd0: begin
        case (ev_q)
          2'd0:    cur_byte = 8'h54;
          2'd1:    cur_byte = 8'h42;
          2'd2:    cur_byte = 8'h4C;
          default: cur_byte = 8'h52;
        endcase
      end
      3'd1:    cur_byte = 8'h20;
      3'd2:    cur_byte = hex_char(min_q);
      3'd3:    cur_byte = 8'h3A;
      3'd4:    cur_byte = hex_char(s10_q);
      3'd5:    cur_byte = hex_char(s1_q);
      3'd6:    cur_byte = 8'h0D;
      default: cur_byte = 8'h0A;
    endcase
  end

  assign next_bit = bit_idx_q + 3'd1;
  assign bit_end  = (cnt_q == BIT_LAST);

  // tx_d carries the level for the next bit so UartTx comes straight from a flop
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    ev_d       = ev_q;
    min_d      = min_q;
    s10_d      = s10_q;
    s1_d       = s1_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = START_BIT;
          ev_d       = event_code;
          min_d      = time_min;
          s10_d      = time_sec_10s;
          s1_d       = time_sec_1s;
          byte_idx_d = 3'd0;
          bit_idx_d  = 3'd0;
          cnt_d      = '0;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
        end
      end
      START_BIT: begin
        if (bit_end) begin
          state_d   = DATA_BITS;
          bit_idx_d = 3'd0;
          tx_d      = cur_byte[0];
        end
      end
      DATA_BITS: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            state_d = STOP_BIT;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = next_bit;
            tx_d      = cur_byte[next_bit];
          end
        end
      end
      STOP_BIT: begin
        if (bit_end) begin
          if (byte_idx_q == 3'd7) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            tx_d    = 1'b1;
          end else begin
            state_d    = START_BIT;
            byte_idx_d = byte_idx_q + 3'd1;
            tx_d       = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 3'd0;
      ev_q       <= 2'd0;
      min_q      <= 4'd0;
      s10_q      <= 4'd0;
      s1_q       <= 4'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      ev_q       <= ev_d;
      min_q      <= min_d;
      s10_q      <= s10_d;
      s1_q       <= s1_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign UartTx = tx_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

`default_nettype wire

// File: tb/tb_nexys_starship_uart_report.sv
// ============================================================================
// tb_nexys_starship_uart_report: directed checks of the game-over report UART
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nexys_starship_uart_report;

  // Bit time shortened so several full reports fit in a short run
  localparam int CLK_HZ = 100_000_000;
  localparam int BAUD   = 6_250_000;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int FRAME  = 80 * CPB;

  logic       board_clk = 1'b0;
  logic       Reset     = 1'b1;
  logic       start     = 1'b0;
  logic [1:0] event_code   = 2'd0;
  logic [3:0] time_min     = 4'd0;
  logic [3:0] time_sec_10s = 4'd0;
  logic [3:0] time_sec_1s  = 4'd0;
  logic       UartTx;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_bad = 0;

  nexys_starship_uart_report #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) dut (
    .board_clk   (board_clk),
    .Reset       (Reset),
    .start       (start),
    .event_code  (event_code),
    .time_min    (time_min),
    .time_sec_10s(time_sec_10s),
    .time_sec_1s (time_sec_1s),
    .UartTx      (UartTx),
    .busy        (busy),
    .done        (done)
  );

  always #5 board_clk = ~board_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_level(input int c, input logic [63:0] msg);
    int b;
    int k;
    int p;
    logic [7:0] by;
    b  = c / CPB;
    k  = b / 10;
    p  = b % 10;
    by = msg[63-8*k -: 8];
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return by[p-1];
  endfunction

  // Issues one start, then checks every cycle of the frame against the
  // expected waveform. With disturb set, a second start plus changed inputs
  // are applied part-way through.
  task automatic send_and_check(input string name, input logic [1:0] ev, input logic [3:0] mn,
                                input logic [3:0] s10, input logic [3:0] s1,
                                input logic [63:0] msg, input bit disturb);
    int hits [80];
    logic [7:0] rx [8];
    int busy_cnt;
    int done_cnt;
    int idle_hi;
    int b;
    int p;
    for (int i = 0; i < 80; i++) hits[i] = 0;
    for (int i = 0; i < 8; i++) rx[i] = 8'h00;
    busy_cnt = 0;
    done_cnt = 0;
    @(negedge board_clk);
    event_code   = ev;
    time_min     = mn;
    time_sec_10s = s10;
    time_sec_1s  = s1;
    start        = 1'b1;
    @(negedge board_clk);
    start = 1'b0;
    for (int c = 0; c < FRAME; c++) begin
      b = c / CPB;
      p = b % 10;
      if (UartTx === exp_level(c, msg)) hits[b]++;
      if (busy === 1'b1) busy_cnt++;
      if (done !== 1'b0) done_cnt++;
      if ((c % CPB) == CPB / 2 && p >= 1 && p <= 8) rx[b/10][p-1] = UartTx;
      if (disturb && c == 20 * CPB + 5) begin
        start       = 1'b1;
        event_code  = 2'd0;
        time_sec_1s = 4'd3;
      end
      if (disturb && c == 20 * CPB + 6) start = 1'b0;
      @(negedge board_clk);
    end
    for (int i = 0; i < 80; i++) check_eq($sformatf("%s bit%0d level/width", name, i), hits[i], CPB);
    for (int i = 0; i < 8; i++) check_eq($sformatf("%s byte%0d", name, i), {24'h0, rx[i]}, {24'h0, msg[63-8*i -: 8]});
    check_eq({name, " busy throughout"}, busy_cnt, FRAME);
    check_eq({name, " early done"}, done_cnt, 0);
    check_eq({name, " done at end"}, {31'h0, done}, 1);
    check_eq({name, " busy cleared at end"}, {31'h0, busy}, 0);
    check_eq({name, " line high at end"}, {31'h0, UartTx}, 1);
    @(negedge board_clk);
    check_eq({name, " done one cycle"}, {31'h0, done}, 0);
    idle_hi = 0;
    for (int c = 0; c < 4 * CPB; c++) begin
      if (UartTx === 1'b1 && busy === 1'b0 && done === 1'b0) idle_hi++;
      @(negedge board_clk);
    end
    check_eq({name, " idle after report"}, idle_hi, 4 * CPB);
  endtask

  initial begin
    int hi_cnt;
    int done_seen;

    // Reset state
    repeat (5) @(posedge board_clk);
    @(negedge board_clk);
    check_eq("reset UartTx", {31'h0, UartTx}, 1);
    check_eq("reset busy", {31'h0, busy}, 0);
    check_eq("reset done", {31'h0, done}, 0);
    Reset = 1'b0;
    hi_cnt = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge board_clk);
      if (UartTx === 1'b1 && busy === 1'b0) hi_cnt++;
    end
    check_eq("idle line after reset", hi_cnt, 2000);

    // 'L' ' ' '2' ':' '4' '7' CR LF
    send_and_check("basic", 2'd2, 4'd2, 4'd4, 4'd7, 64'h4C20_323A_3437_0D0A, 1'b0);
    // Second start and input changes mid-message must not alter anything
    send_and_check("latch", 2'd2, 4'd2, 4'd4, 4'd7, 64'h4C20_323A_3437_0D0A, 1'b1);
    // 'R' ' ' 'B' ':' 'F' '0' CR LF
    send_and_check("hex", 2'd3, 4'd11, 4'd15, 4'd0, 64'h5220_423A_4630_0D0A, 1'b0);

    // Reset during byte3
    @(negedge board_clk);
    event_code   = 2'd1;
    time_min     = 4'd9;
    time_sec_10s = 4'd5;
    time_sec_1s  = 4'd9;
    start        = 1'b1;
    @(negedge board_clk);
    start = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 34 * CPB; c++) begin
      if (done !== 1'b0) done_seen++;
      @(negedge board_clk);
    end
    check_eq("pre-reset busy", {31'h0, busy}, 1);
    Reset = 1'b1;
    #1;
    check_eq("async reset UartTx", {31'h0, UartTx}, 1);
    check_eq("async reset busy", {31'h0, busy}, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge board_clk);
      if (done !== 1'b0) done_seen++;
    end
    Reset = 1'b0;
    for (int c = 0; c < 2 * FRAME; c++) begin
      @(negedge board_clk);
      if (done !== 1'b0) done_seen++;
    end
    check_eq("no done after abort", done_seen, 0);
    check_eq("line idle after abort", {31'h0, UartTx}, 1);
    // 'B' ' ' '9' ':' '5' '9' CR LF
    send_and_check("fresh", 2'd1, 4'd9, 4'd5, 4'd9, 64'h4220_393A_3539_0D0A, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
